map_step_seq: RTL and testbench
===============================

# map_step_seq

Parametrised trellis-step sequencer for the MAP decoder: generates the per-cycle step index for the alpha/beta recursion units. It runs a prologue of `PRE_STEPS` steps, then `NUM_WIN` windows of `LOOP_LEN` steps each, counting ascending (forward) or descending (backward). It replaces the fixed 0..5 / wrap-to-2 counter with start/done handshaking, stall, window tracking and abort.

## Interface
- `PRE_STEPS`, default 2: prologue steps, indices 0..PRE_STEPS-1; 0 allowed (prologue skipped).
- `LOOP_LEN`, default 4: steps per window, indices PRE_STEPS..PRE_STEPS+LOOP_LEN-1; must be ≥1.
- `NUM_WIN`, default 3: windows per frame; must be ≥1.
- `CNT_W`, default 4: step width; elaboration error if 2^CNT_W < PRE_STEPS+LOOP_LEN.
- `WIN_W`, default 4: window-count width; elaboration error if 2^WIN_W ≤ NUM_WIN.
- `clk` in 1: clock. Single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: frame start request; sampled only in IDLE or DONE.
- `dir` in 1: 0 = forward (loop ascending), 1 = backward (loop descending); latched on accepted start.
- `en` in 1: advance enable; 0 stalls all state.
- `abort` in 1: frame abort (see Configuration).
- `step` out CNT_W: current trellis step index.
- `win_cnt` out WIN_W: completed windows in current frame.
- `busy` out 1: high in PRE and LOOP.
- `win_done` out 1: one-cycle pulse after each completed window.
- `done` out 1: one-cycle pulse; frame complete.

## Operation
- States: IDLE, PRE, LOOP, DONE.
- Reset (any state, any cycle): state IDLE; step=0, win_cnt=0, busy=0, win_done=0, done=0; latched dir=0.
- IDLE/DONE + start=1: latch dir; win_cnt←0. Go to PRE with step=0, or to LOOP if PRE_STEPS=0. Loop entry: step=PRE_STEPS (forward) or PRE_STEPS+LOOP_LEN-1 (backward).
- start is ignored in PRE/LOOP. `en` is not required for start acceptance.
- PRE, en=1: step+1. At step=PRE_STEPS-1, go to LOOP at the loop entry index for the latched dir. Prologue is always ascending.
- LOOP, en=1: forward step+1, backward step-1, until the window's last index (forward PRE_STEPS+LOOP_LEN-1, backward PRE_STEPS).
- At the last index: win_cnt+1, win_done pulses next cycle, step reloads the loop entry index. If this was window NUM_WIN, go to DONE instead; step holds its last value.
- LOOP_LEN=1: every loop cycle completes a window.
- DONE: done=1, busy=0 for exactly one cycle. Without start, go to IDLE with step←0; win_cnt holds until the next start.
- en=0 in PRE/LOOP: step, win_cnt and state hold; win_done/done are not generated.

## Timing
- All outputs registered; no combinational input→output path.
- Start accepted at edge E0: busy=1 and step=first index from the cycle after E0.
- With en held 1, the frame spans T = PRE_STEPS + NUM_WIN·LOOP_LEN cycles; done=1 in cycle T+1 after E0.
- win_done coincides with the first step of the next window. For the final window it coincides with done.
- Back-to-back frames: start during the DONE cycle gives step=first index in the next cycle, with no IDLE bubble.

## Configuration
- `MAP_STEP_ABORT_EN` defined: abort=1 in PRE/LOOP forces IDLE at the next edge.
  - step=0, win_cnt=0, busy=0; no win_done/done pulse.
  - Abort takes priority over en and window completion.
  - In IDLE/DONE, abort is ignored, and start wins if both are high in DONE.
- Undefined: the abort port exists but is ignored; a frame can only end via done or rst.

## Structure
- Shared package `map_dec_pkg`: state enum `map_step_state_t` (IDLE, PRE, LOOP, DONE) and constants `MAP_DIR_FWD=1'b0`, `MAP_DIR_BWD=1'b1`.
- Single flat module; no sub-module is natural.

## Test plan
- Defaults, dir=0, en=1, start pulse → step 0,1,2,3,4,5,2,3,4,5,2,3,4,5; win_cnt 1,2,3 at window ends; win_done three pulses; done in cycle 15.
- dir=1 → step 0,1,5,4,3,2,5,4,3,2,5,4,3,2; done in cycle 15.
- en toggled 1,0,1,0 throughout → identical step sequence, each value held two cycles; done in cycle 29.
- start during DONE → new frame begins step=0 the next cycle; start during LOOP → ignored, sequence unchanged.
- rst at step=4 in window 2 → next cycle all outputs 0, state IDLE.
- Abort with `MAP_STEP_ABORT_EN` at step=3 → IDLE next cycle, no done. Without the macro → frame completes normally.
- PRE_STEPS=0, LOOP_LEN=1, NUM_WIN=2 → step 0,0, win_done each cycle, done in cycle 3.

Source files
------------

// File: rtl/map_dec_pkg.sv
// Shared MAP decoder types: trellis-step sequencer state encoding and direction constants.
package map_dec_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    LOOP = 2'd2,
    DONE = 2'd3
  } map_step_state_t;

  localparam logic MAP_DIR_FWD = 1'b0;
  localparam logic MAP_DIR_BWD = 1'b1;

endpackage

// File: rtl/map_step_seq.sv
// Trellis-step sequencer for the MAP alpha/beta recursions: prologue, then NUM_WIN windows.
// Define MAP_STEP_ABORT_EN to let abort drop an active frame back to IDLE.
module map_step_seq
  import map_dec_pkg::*;
#(
  parameter int PRE_STEPS = 2,
  parameter int LOOP_LEN  = 4,
  parameter int NUM_WIN   = 3,
  parameter int CNT_W     = 4,
  parameter int WIN_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dir,
  input  logic             en,
  input  logic             abort,
  output logic [CNT_W-1:0] step,
  output logic [WIN_W-1:0] win_cnt,
  output logic             busy,
  output logic             win_done,
  output logic             done
);

  localparam logic [CNT_W-1:0] LOOP_FIRST = CNT_W'(PRE_STEPS);
  localparam logic [CNT_W-1:0] LOOP_LAST  = CNT_W'(PRE_STEPS + LOOP_LEN - 1);
  localparam logic [CNT_W-1:0] PRE_LAST   = CNT_W'((PRE_STEPS > 0) ? PRE_STEPS - 1 : 0);
  localparam logic [WIN_W-1:0] WIN_LAST   = WIN_W'(NUM_WIN);

  if (PRE_STEPS < 0) begin : g_pre_chk
    $error("map_step_seq: PRE_STEPS must be >= 0");
  end
  if (LOOP_LEN < 1) begin : g_loop_chk
    $error("map_step_seq: LOOP_LEN must be >= 1");
  end
  if (NUM_WIN < 1) begin : g_win_chk
    $error("map_step_seq: NUM_WIN must be >= 1");
  end
  if ((2 ** CNT_W) < (PRE_STEPS + LOOP_LEN)) begin : g_cnt_w_chk
    $error("map_step_seq: CNT_W too narrow for PRE_STEPS+LOOP_LEN");
  end
  if ((2 ** WIN_W) <= NUM_WIN) begin : g_win_w_chk
    $error("map_step_seq: WIN_W too narrow for NUM_WIN");
  end

  map_step_state_t  state_q, state_d;
  logic [CNT_W-1:0] step_q, step_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic             dir_q, dir_d;
  logic             busy_q, busy_d;
  logic             win_done_q, win_done_d;
  logic             done_q, done_d;
  logic             abort_act;

`ifdef MAP_STEP_ABORT_EN
  assign abort_act = abort;
`else
  assign abort_act = abort & 1'b0;
`endif

  // Forward windows enter at the low index and exit at the high one; backward is mirrored.
  function automatic logic [CNT_W-1:0] loop_entry(input logic d);
    return (d == MAP_DIR_BWD) ? LOOP_LAST : LOOP_FIRST;
  endfunction

  function automatic logic [CNT_W-1:0] loop_exit(input logic d);
    return (d == MAP_DIR_BWD) ? LOOP_FIRST : LOOP_LAST;
  endfunction

  // Next-state and next-output computation.
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    win_cnt_d  = win_cnt_q;
    dir_d      = dir_q;
    win_done_d = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          dir_d     = dir;
          win_cnt_d = {WIN_W{1'b0}};
          if (PRE_STEPS == 0) begin
            state_d = LOOP;
            step_d  = loop_entry(dir);
          end else begin
            state_d = PRE;
            step_d  = {CNT_W{1'b0}};
          end
        end else if (state_q == DONE) begin
          state_d = IDLE;
          step_d  = {CNT_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      PRE, LOOP: begin
        if (abort_act) begin
          state_d   = IDLE;
          step_d    = {CNT_W{1'b0}};
          win_cnt_d = {WIN_W{1'b0}};
        end else if (!en) begin
          state_d = state_q;
        end else if (state_q == PRE) begin
          if (step_q == PRE_LAST) begin
            state_d = LOOP;
            step_d  = loop_entry(dir_q);
          end else begin
            step_d = step_q + CNT_W'(1);
          end
        end else if (step_q == loop_exit(dir_q)) begin
          win_cnt_d  = win_cnt_q + WIN_W'(1);
          win_done_d = 1'b1;
          // Last window: step keeps its final index through DONE.
          if ((win_cnt_q + WIN_W'(1)) == WIN_LAST) begin
            state_d = DONE;
          end else begin
            step_d = loop_entry(dir_q);
          end
        end else if (dir_q == MAP_DIR_BWD) begin
          step_d = step_q - CNT_W'(1);
        end else begin
          step_d = step_q + CNT_W'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        step_d    = {CNT_W{1'b0}};
        win_cnt_d = {WIN_W{1'b0}};
      end
    endcase
    busy_d = (state_d == PRE) || (state_d == LOOP);
    done_d = (state_d == DONE) && (state_q != DONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      step_q     <= {CNT_W{1'b0}};
      win_cnt_q  <= {WIN_W{1'b0}};
      dir_q      <= MAP_DIR_FWD;
      busy_q     <= 1'b0;
      win_done_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      win_cnt_q  <= win_cnt_d;
      dir_q      <= dir_d;
      busy_q     <= busy_d;
      win_done_q <= win_done_d;
      done_q     <= done_d;
    end
  end

  assign step     = step_q;
  assign win_cnt  = win_cnt_q;
  assign busy     = busy_q;
  assign win_done = win_done_q;
  assign done     = done_q;

endmodule

// File: tb/tb_map_step_seq.sv
// Self-checking bench for map_step_seq: two configurations driven by shared random stimulus.
module tb_map_step_seq;

  logic       clk = 1'b0;
  logic       rst, start, dir, en, abort;
  logic [3:0] step_a, win_a, step_b;
  logic [1:0] win_b;
  logic       busy_a, wd_a, done_a, busy_b, wd_b, done_b;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef MAP_STEP_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  // Configuration of each instance: a = defaults, b = no prologue, single-step windows.
  int cfg_p[2] = '{2, 0};
  int cfg_l[2] = '{4, 1};
  int cfg_n[2] = '{3, 2};

  bit m_act[2], m_indone[2], m_dir[2], m_busy[2], m_wd[2], m_done[2];
  int m_pos[2], m_step[2], m_win[2];

  map_step_seq u_dut_a (
    .clk(clk), .rst(rst), .start(start), .dir(dir), .en(en), .abort(abort),
    .step(step_a), .win_cnt(win_a), .busy(busy_a), .win_done(wd_a), .done(done_a)
  );

  map_step_seq #(.PRE_STEPS(0), .LOOP_LEN(1), .NUM_WIN(2), .CNT_W(4), .WIN_W(2)) u_dut_b (
    .clk(clk), .rst(rst), .start(start), .dir(dir), .en(en), .abort(abort),
    .step(step_b), .win_cnt(win_b), .busy(busy_b), .win_done(wd_b), .done(done_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0d expected=%0d", tag, $time, obs, exp);
    end
  endtask

  // Step index at frame position pos: prologue ascends, each window walks its range.
  function automatic int step_at(input int i, input int pos, input bit d);
    int k;
    if (pos < cfg_p[i]) return pos;
    k = (pos - cfg_p[i]) % cfg_l[i];
    return d ? (cfg_p[i] + cfg_l[i] - 1 - k) : (cfg_p[i] + k);
  endfunction

  task automatic model_step(input int i);
    int t;
    t = cfg_p[i] + cfg_n[i] * cfg_l[i];
    if (rst) begin
      m_act[i] = 0; m_indone[i] = 0; m_dir[i] = 0; m_pos[i] = 0;
      m_step[i] = 0; m_win[i] = 0; m_busy[i] = 0; m_wd[i] = 0; m_done[i] = 0;
    end else if (!m_act[i]) begin
      if (start) begin
        m_dir[i] = dir; m_act[i] = 1; m_pos[i] = 0; m_indone[i] = 0;
        m_step[i] = step_at(i, 0, dir); m_win[i] = 0;
        m_busy[i] = 1; m_wd[i] = 0; m_done[i] = 0;
      end else begin
        if (m_indone[i]) m_step[i] = 0;
        m_indone[i] = 0; m_busy[i] = 0; m_wd[i] = 0; m_done[i] = 0;
      end
    end else if (ABORT_EN && abort) begin
      m_act[i] = 0; m_step[i] = 0; m_win[i] = 0;
      m_busy[i] = 0; m_wd[i] = 0; m_done[i] = 0;
    end else if (en) begin
      m_pos[i]++;
      m_win[i] = (m_pos[i] <= cfg_p[i]) ? 0 : (m_pos[i] - cfg_p[i]) / cfg_l[i];
      m_wd[i]  = (m_pos[i] > cfg_p[i]) && ((m_pos[i] - cfg_p[i]) % cfg_l[i] == 0);
      if (m_pos[i] == t) begin
        m_act[i] = 0; m_indone[i] = 1; m_done[i] = 1; m_busy[i] = 0;
      end else begin
        m_step[i] = step_at(i, m_pos[i], m_dir[i]);
      end
    end else begin
      m_wd[i] = 0; m_done[i] = 0;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check("a.step", step_a, m_step[0]);
    check("a.win_cnt", win_a, m_win[0]);
    check("a.busy", busy_a, m_busy[0]);
    check("a.win_done", wd_a, m_wd[0]);
    check("a.done", done_a, m_done[0]);
    check("b.step", step_b, m_step[1]);
    check("b.win_cnt", win_b, m_win[1]);
    check("b.busy", busy_b, m_busy[1]);
    check("b.win_done", wd_b, m_wd[1]);
    check("b.done", done_b, m_done[1]);
  endtask

  // One frame from a start pulse; records the cycle (counted from the start edge) of the first done.
  task automatic frame(input bit d, input bit toggle, input int exp_a, input int exp_b);
    int da, db;
    da = 0; db = 0;
    start = 1'b1; dir = d; en = 1'b1;
    cyc();
    for (int n = 1; n <= 40; n++) begin
      start = (!toggle && n == 8);
      dir   = 1'($urandom);
      en    = toggle ? (n % 2 == 0) : 1'b1;
      cyc();
      if (done_a && da == 0) da = n + 1;
      if (done_b && db == 0) db = n + 1;
    end
    start = 1'b0;
    check("a.done_cycle", da, exp_a);
    check("b.done_cycle", db, exp_b);
  endtask

  initial begin
    int guard;
    rst = 1'b1; start = 1'b0; dir = 1'b0; en = 1'b0; abort = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    cyc();

    frame(1'b0, 1'b0, 15, 3);
    frame(1'b1, 1'b0, 15, 3);
    frame(1'b0, 1'b1, 29, 5);

    // Back-to-back: start raised during the DONE cycle.
    start = 1'b1; dir = 1'b0; en = 1'b1;
    cyc();
    start = 1'b0;
    for (int n = 1; n < 15; n++) cyc();
    check("a.b2b_done", done_a, 1);
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("a.b2b_restart", step_a, 0);
    for (int n = 0; n < 20; n++) cyc();

    // Synchronous reset at step 4 of the second window.
    start = 1'b1; dir = 1'b0;
    cyc();
    start = 1'b0;
    guard = 0;
    while (!(step_a == 4'd4 && win_a == 4'd1) && guard < 100) begin
      cyc();
      guard++;
    end
    check("a.rst_reach", int'(guard < 100), 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("a.rst_step", step_a, 0);
    check("a.rst_busy", busy_a, 0);

    // Abort at step 3.
    start = 1'b1; dir = 1'b0;
    cyc();
    start = 1'b0;
    guard = 0;
    while (step_a != 4'd3 && guard < 100) begin
      cyc();
      guard++;
    end
    check("a.abort_reach", int'(guard < 100), 1);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    check("a.abort_busy", busy_a, ABORT_EN ? 0 : 1);
    for (int n = 0; n < 30; n++) cyc();

    // Randomized stimulus.
    for (int n = 0; n < 3000; n++) begin
      start = ($urandom_range(0, 9) == 0);
      dir   = 1'($urandom);
      en    = ($urandom_range(0, 3) != 0);
      abort = ($urandom_range(0, 29) == 0);
      rst   = ($urandom_range(0, 199) == 0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
